// File: rtl/sign_mag_pkg.sv
// ---------------------------------------------------------------------------
// sign_mag_pkg
// Shared declarations for the sign-magnitude frame accumulator:
//   - state_t     : frame FSM states (IDLE, ACCUM, DONE)
//   - sat_mag()   : all-ones magnitude constant used when saturating
// ---------------------------------------------------------------------------
package sign_mag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest magnitude representable in an acc_w-bit sign-magnitude word,
  // i.e. 2^(acc_w-1)-1. Returned wide; callers truncate to their width.
  function automatic logic [63:0] sat_mag(input int unsigned acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// ---------------------------------------------------------------------------
// sm_add_core
// Purely combinational sign-magnitude adder at W bits (1 sign + W-1 magnitude).
//   a_sign, a_mag : first operand
//   b_sign, b_mag : second operand
//   sum_sign      : result sign (never set for a zero magnitude)
//   sum_mag       : result magnitude, modulo 2^(W-1) on carry
//   carry         : magnitude carry out of bit W-2 (only possible on equal signs)
// ---------------------------------------------------------------------------
module sm_add_core #(
  parameter int W = 8
) (
  input  logic         a_sign,
  input  logic [W-2:0] a_mag,
  input  logic         b_sign,
  input  logic [W-2:0] b_mag,
  output logic         sum_sign,
  output logic [W-2:0] sum_mag,
  output logic         carry
);

  logic [W-1:0] ext_sum;

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ext_sum  = '0;
    sum_sign = 1'b0;
    sum_mag  = '0;
    carry    = 1'b0;
    if (a_sign == b_sign) begin
      ext_sum  = {1'b0, a_mag} + {1'b0, b_mag};
      sum_mag  = ext_sum[W-2:0];
      carry    = ext_sum[W-1];
      sum_sign = a_sign;
    end else if (a_mag >= b_mag) begin
      sum_mag  = a_mag - b_mag;
      sum_sign = a_sign;
    end else begin
      sum_mag  = b_mag - a_mag;
      sum_sign = b_sign;
    end
    // Cancellation (or a wrap landing on zero) must never yield -0.
    if (sum_mag == '0) begin
      sum_sign = 1'b0;
    end
  end

endmodule

// File: rtl/sign_mag_accum.sv
// ---------------------------------------------------------------------------
// sign_mag_accum
// Accumulates LEN sign-magnitude operands per frame and presents the
// sign-magnitude sum with a sticky magnitude-overflow flag.
//
// Parameters
//   N     : operand width (MSB = sign)
//   ACC_W : accumulator/result width (MSB = sign), ACC_W > N
//   LEN   : operands per frame, LEN >= 1
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand present
//   in_ready  : block accepts an operand (IDLE / ACCUM)
//   in_data   : sign-magnitude operand
//   out_valid : frame result present (DONE)
//   out_ready : consumer accepts the result
//   out_data  : sign-magnitude frame sum
//   out_ovf   : magnitude overflow occurred during the frame
//
// Configuration
//   SIGN_MAG_ACCUM_SAT_EN defined   : overflow saturates the magnitude to
//                                     all-ones, keeping the current sign.
//   SIGN_MAG_ACCUM_SAT_EN undefined : overflow wraps the magnitude modulo
//                                     2^(ACC_W-1). ovf is flagged either way.
// ---------------------------------------------------------------------------
module sign_mag_accum
  import sign_mag_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int MAG_W = ACC_W - 1;
  localparam int CNT_W = $clog2(LEN + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
`ifdef SIGN_MAG_ACCUM_SAT_EN
  localparam logic [MAG_W-1:0] SAT_MAG  = MAG_W'(sat_mag(ACC_W));
`endif

  state_t             state, state_next;
  logic               acc_sign, acc_sign_next;
  logic [MAG_W-1:0]   acc_mag, acc_mag_next;
  logic [CNT_W-1:0]   count, count_next, count_inc;
  logic               ovf, ovf_next;

  logic               take;
  logic               op_sign;
  logic [MAG_W-1:0]   op_mag;
  logic               sum_sign;
  logic [MAG_W-1:0]   sum_mag;
  logic               sum_carry;

  // Operand decode: zero-extend the magnitude and fold -0 into +0.
  assign op_mag  = {{(ACC_W - N){1'b0}}, in_data[N-2:0]};
  assign op_sign = in_data[N-1] & (|in_data[N-2:0]);

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign take      = in_valid && in_ready;
  assign count_inc = count + ONE_CNT;

  // Result is only meaningful in DONE; outside it the outputs read as zero.
  assign out_data = out_valid ? {acc_sign, acc_mag} : '0;
  assign out_ovf  = out_valid & ovf;

  sm_add_core #(
    .W (ACC_W)
  ) u_add (
    .a_sign   (acc_sign),
    .a_mag    (acc_mag),
    .b_sign   (op_sign),
    .b_mag    (op_mag),
    .sum_sign (sum_sign),
    .sum_mag  (sum_mag),
    .carry    (sum_carry)
  );

  always_comb begin
    state_next    = state;
    acc_sign_next = acc_sign;
    acc_mag_next  = acc_mag;
    count_next    = count;
    ovf_next      = ovf;

    case (state)
      IDLE: begin
        if (take) begin
          acc_sign_next = op_sign;
          acc_mag_next  = op_mag;
          count_next    = ONE_CNT;
          ovf_next      = 1'b0;
          state_next    = (LEN == 1) ? DONE : ACCUM;
        end
      end

      ACCUM: begin
        if (take) begin
          count_next    = count_inc;
          ovf_next      = ovf | sum_carry;
          acc_sign_next = sum_sign;
          acc_mag_next  = sum_mag;
`ifdef SIGN_MAG_ACCUM_SAT_EN
          // A carry only happens on equal signs, so acc_sign is the sign
          // of the true sum and is kept alongside the clamped magnitude.
          if (sum_carry) begin
            acc_sign_next = acc_sign;
            acc_mag_next  = SAT_MAG;
          end
`endif
          if (count_inc == LAST_CNT) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_next;
      acc_sign <= acc_sign_next;
      acc_mag  <= acc_mag_next;
      count    <= count_next;
      ovf      <= ovf_next;
    end
  end

endmodule

// File: tb/tb_sign_mag_accum.sv
// ---------------------------------------------------------------------------
// tb_sign_mag_accum
// Directed self-checking bench for sign_mag_accum. The main instance uses
// N=4, ACC_W=8, LEN=4; a second instance with LEN=32 exercises overflow.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_sign_mag_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [3:0] in_data;
  logic [7:0] out_data;

  logic       in_valid32, in_ready32, out_valid32, out_ready32, out_ovf32;
  logic [3:0] in_data32;
  logic [7:0] out_data32;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sign_mag_accum #(.N(4), .ACC_W(8), .LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  sign_mag_accum #(.N(4), .ACC_W(8), .LEN(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_data   (in_data32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_data  (out_data32),
    .out_ovf   (out_ovf32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer (in_ready is high in IDLE/ACCUM); afterwards in_data is
  // parked on a junk value to show it is ignored without in_valid.
  task automatic send_op(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 4'hE;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++;
    if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else passed++;
    total++;
    if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b want 0", out_ovf); else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++;
    if (out_valid32 !== 1'b0) $display("FAIL reset_out_valid32: got %b want 0", out_valid32); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Full frame of four operands, exact latency check, then hand-off.
  task automatic test_frame(input string name, input logic [3:0] a, b, c, d,
                            input logic [7:0] exp_data, input logic exp_ovf);
    send_op(a);
    send_op(b);
    send_op(c);
    total++;
    if (out_valid !== 1'b0) $display("FAIL %s_early_valid: got %b want 0", name, out_valid); else passed++;
    send_op(d);
    total++;
    if (out_valid !== 1'b1) $display("FAIL %s_valid: got %b want 1", name, out_valid); else passed++;
    total++;
    if (out_data !== exp_data) $display("FAIL %s_data: got %h want %h", name, out_data, exp_data); else passed++;
    total++;
    if (out_ovf !== exp_ovf) $display("FAIL %s_ovf: got %b want %b", name, out_ovf, exp_ovf); else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL %s_ready_done: got %b want 0", name, in_ready); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_release: got valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_backpressure();
    send_op(4'h7);
    send_op(4'h7);
    send_op(4'h7);
    send_op(4'hF);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'h5;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h0E || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got valid=%b data=%h ready=%b want valid=1 data=0e ready=0",
                 i, out_valid, out_data, in_ready);
      else passed++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    else passed++;
    // Any pulse absorbed during DONE would corrupt this frame.
    test_frame("after_bp", 4'h2, 4'h2, 4'h2, 4'h2, 8'h08, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    // Reset while a result is held must clear outputs without a clock edge.
    send_op(4'h3);
    send_op(4'h3);
    send_op(4'h3);
    send_op(4'h3);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 1'b0)
      $display("FAIL rst_done_async: got valid=%b data=%h ovf=%b want 0/00/0", out_valid, out_data, out_ovf);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Reset after two transfers discards the partial sum.
    send_op(4'h3);
    send_op(4'h5);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid: got valid=%b data=%h ovf=%b ready=%b want 0/00/0/1",
               out_valid, out_data, out_ovf, in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_frame("after_rst", 4'h1, 4'h1, 4'h1, 4'h1, 8'h04, 1'b0);
  endtask

  task automatic test_random_valid();
    int  xfers = 0;
    bit  early = 1'b0;
    logic v;
    for (int i = 0; i < 200 && xfers < 4; i++) begin
      v        = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? 4'h9 : 4'h7;
      #3;
      if (in_valid && in_ready) xfers++;
      @(posedge clk);
      #1;
      if (xfers < 4 && out_valid) early = 1'b1;
    end
    in_valid = 1'b0;
    total++;
    if (xfers !== 4) $display("FAIL rand_xfers: got %0d want 4", xfers); else passed++;
    total++;
    if (early !== 1'b0) $display("FAIL rand_early_valid: got %b want 0", early); else passed++;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h84 || out_ovf !== 1'b0)
      $display("FAIL rand_result: got valid=%b data=%h ovf=%b want 1/84/0", out_valid, out_data, out_ovf);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_data;
`ifdef SIGN_MAG_ACCUM_SAT_EN
    exp_data = 8'h7F;
`else
    exp_data = 8'h60;
`endif
    in_valid32 = 1'b1;
    in_data32  = 4'h7;
    repeat (31) tick();
    total++;
    if (out_valid32 !== 1'b0) $display("FAIL ovf_early_valid: got %b want 0", out_valid32); else passed++;
    tick();
    in_valid32 = 1'b0;
    total++;
    if (out_valid32 !== 1'b1) $display("FAIL ovf_valid: got %b want 1", out_valid32); else passed++;
    total++;
    if (out_data32 !== exp_data) $display("FAIL ovf_data: got %h want %h", out_data32, exp_data); else passed++;
    total++;
    if (out_ovf32 !== 1'b1) $display("FAIL ovf_flag: got %b want 1", out_ovf32); else passed++;
    out_ready32 = 1'b1;
    tick();
    out_ready32 = 1'b0;
    total++;
    if (out_valid32 !== 1'b0) $display("FAIL ovf_release: got %b want 0", out_valid32); else passed++;
  endtask

  initial begin
    in_valid    = 1'b0;
    in_data     = 4'h0;
    out_ready   = 1'b0;
    in_valid32  = 1'b0;
    in_data32   = 4'h0;
    out_ready32 = 1'b0;

    test_reset();
    test_frame("mixed",    4'h3, 4'hD, 4'h7, 4'hA, 8'h03, 1'b0);
    test_frame("neg_zero", 4'h3, 4'hB, 4'h0, 4'h8, 8'h00, 1'b0);
    test_frame("negative", 4'hB, 4'hD, 4'h1, 4'h8, 8'h87, 1'b0);
    test_frame("max_pos",  4'h7, 4'h7, 4'h7, 4'h7, 8'h1C, 1'b0);
    test_backpressure();
    test_reset_mid_frame();
    test_random_valid();
    test_overflow();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
